// File: rtl/ppu_bg_fetch.sv
// Background tile fetcher: runs the NT/AT/PT_LO/PT_HI fetch cycle every 8 clocks
// and feeds four 16-bit shifters that produce a per-pixel palette index.
module ppu_bg_fetch (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        render_en,
  input  logic        line_start,
  input  logic [1:0]  nt_sel_in,
  input  logic [4:0]  coarse_x_in,
  input  logic [4:0]  coarse_y_in,
  input  logic [2:0]  fine_y_in,
  input  logic [2:0]  fine_x,
  input  logic        pattern_base,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic        mem_rd,
  output logic [3:0]  pix_out,
  output logic        pix_valid,
  output logic [2:0]  dbg_phase
);

  logic [2:0]  phase;
  logic [1:0]  nt;
  logic [4:0]  cx;
  logic [4:0]  cy;
  logic [2:0]  fine_y;
  logic [7:0]  tile;
  logic [1:0]  at_bits;
  logic [7:0]  pt_lo;
  logic [15:0] sh_plo;
  logic [15:0] sh_phi;
  logic [15:0] sh_alo;
  logic [15:0] sh_ahi;
  logic [1:0]  reload_cnt;

  logic [2:0]  at_shift;
  logic [7:0]  at_shifted;
  logic [3:0]  bit_sel;

  // The attribute byte covers a 4x4 tile block; cy[1]/cx[1] pick its 2x2 quadrant.
  assign at_shift   = {cy[1], cx[1], 1'b0};
  assign at_shifted = mem_data >> at_shift;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      phase      <= 3'd0;
      nt         <= 2'd0;
      cx         <= 5'd0;
      cy         <= 5'd0;
      fine_y     <= 3'd0;
      tile       <= 8'd0;
      at_bits    <= 2'd0;
      pt_lo      <= 8'd0;
      sh_plo     <= 16'd0;
      sh_phi     <= 16'd0;
      sh_alo     <= 16'd0;
      sh_ahi     <= 16'd0;
      reload_cnt <= 2'd0;
    end else if (line_start) begin
      phase      <= 3'd0;
      nt         <= nt_sel_in;
      cx         <= coarse_x_in;
      cy         <= coarse_y_in;
      fine_y     <= fine_y_in;
      sh_plo     <= 16'd0;
      sh_phi     <= 16'd0;
      sh_alo     <= 16'd0;
      sh_ahi     <= 16'd0;
      reload_cnt <= 2'd0;
    end else if (render_en) begin
      phase <= phase + 3'd1;
      case (phase)
        3'd1:    tile    <= mem_data;
        3'd3:    at_bits <= at_shifted[1:0];
        3'd5:    pt_lo   <= mem_data;
        default: ;
      endcase
      if (phase == 3'd7) begin
        // PT_HI is consumed straight off the bus on the reload edge.
        sh_plo <= {sh_plo[14:7], pt_lo};
        sh_phi <= {sh_phi[14:7], mem_data};
        sh_alo <= {sh_alo[14:7], {8{at_bits[0]}}};
        sh_ahi <= {sh_ahi[14:7], {8{at_bits[1]}}};
        cx     <= cx + 5'd1;
        if (cx == 5'd31) nt[0] <= ~nt[0];
        // Holds at 2 so pix_valid stays up for the rest of the line.
        if (reload_cnt != 2'd2) reload_cnt <= reload_cnt + 2'd1;
      end else begin
        sh_plo <= {sh_plo[14:0], 1'b0};
        sh_phi <= {sh_phi[14:0], 1'b0};
        sh_alo <= {sh_alo[14:0], 1'b0};
        sh_ahi <= {sh_ahi[14:0], 1'b0};
      end
    end
  end

  always_comb begin
    mem_addr = 16'h2000;
    case (phase[2:1])
      2'd0:    mem_addr = {4'b0010, nt, cy, cx};
      2'd1:    mem_addr = {4'b0010, nt, 4'b1111, cy[4:2], cx[4:2]};
      default: mem_addr = {3'b000, pattern_base, tile, phase[1], fine_y};
    endcase
  end

  assign mem_rd    = RESET_n & render_en & ~line_start;
  assign pix_valid = render_en & (reload_cnt == 2'd2);
  assign bit_sel   = 4'd15 - {1'b0, fine_x};
  assign pix_out   = {sh_ahi[bit_sel], sh_alo[bit_sel], sh_phi[bit_sel], sh_plo[bit_sel]};
  assign dbg_phase = phase;

endmodule

// File: doc/ppu_bg_fetch.md
PPU_BG_FETCH -- requirements
Module: ppu_bg_fetch

Interface
REQ-001 Parameters: none.
REQ-002 CLK  in  1  system clock; all state changes on rising edge.
REQ-003 RESET_n  in  1  asynchronous, active-low reset.
REQ-004 render_en  in  1  1 = fetch, shift and advance; 0 = freeze all state.
REQ-005 line_start  in  1  one-cycle pulse that loads the scroll inputs and restarts the fetch sequence.
REQ-006 nt_sel_in  in  2  starting nametable (PPUCTRL[1:0]).
REQ-007 coarse_x_in  in  5  starting tile column.
REQ-008 coarse_y_in  in  5  tile row.
REQ-009 fine_y_in  in  3  pixel row within the tile.
REQ-010 fine_x  in  3  pixel select within the shifters; sampled every cycle.
REQ-011 pattern_base  in  1  background pattern table select (PPUCTRL[4]).
REQ-012 mem_addr  out  16  PPU memory address; this block drives the downstream memory's primary address port.
REQ-013 mem_data  in  8  read data; valid in the same cycle as mem_addr.
REQ-014 mem_rd  out  1  high when mem_addr carries a valid fetch.
REQ-015 pix_out  out  4  background palette index {attr[1:0], pattern[1:0]}.
REQ-016 pix_valid  out  1  pix_out is meaningful.

Function
REQ-017 A 3-bit phase counter SHALL advance 0..7 and wrap every cycle while render_en=1; it SHALL hold while render_en=0.
REQ-018 The fetch schedule SHALL be as follows; each fetch holds its address for 2 cycles, and data SHALL be captured at the edge ending the odd phase.
- Phases 0-1: NT fetch, address 0x2000|nt<<10|cy<<5|cx; captured value is the tile index.
- Phases 2-3: AT fetch, address 0x23C0|nt<<10|cy[4:2]<<3|cx[4:2].
- Phases 4-5: PT_LO fetch, address pattern_base<<12|tile<<4|fine_y.
- Phases 6-7: PT_HI fetch, the PT_LO address +8.
REQ-019 Attribute selection SHALL use the 2-bit field at bit position {cy[1],cx[1],1'b0} of the AT byte.
REQ-020 mem_rd SHALL equal render_en, except that it SHALL be 0 during the cycle in which line_start is asserted.
REQ-021 Shifting SHALL use four 16-bit shifters: pattern lo, pattern hi, attr lo, attr hi.
- Each cycle with render_en=1, every shifter SHALL shift left by 1.
- At the edge ending phase 7, each shifter SHALL become {old[14:7], new_byte}.
- For the attr shifters, new_byte SHALL be the selected attribute bit replicated 8 times.
REQ-022 pix_out SHALL be taken from bit (15-fine_x) of each shifter, combinationally.
REQ-023 At the edge ending phase 7, cx SHALL increment; when cx wraps 31->0, nt[0] SHALL toggle. cy, fine_y and nt[1] SHALL never change except on line_start.
REQ-024 On line_start, the block SHALL load nt/cx/cy/fine_y from the inputs, force phase to 0, clear the shifters and reload count, and deassert pix_valid. This applies regardless of render_en or the current phase, and aborts any fetch in progress.
REQ-025 A 2-bit saturating reload counter SHALL count phase-7 reloads since line_start. pix_valid SHALL equal render_en AND (count==2).
REQ-026 When render_en=0, mem_addr SHALL keep presenting the current phase's address.

Reset
REQ-027 While RESET_n=0, the block SHALL hold the following values:
- phase=0, nt=0, cx=0, cy=0, fine_y=0.
- All shifters, latches and the reload count = 0.
- mem_addr=0x2000, mem_rd=0, pix_out=0, pix_valid=0.
REQ-028 Deassertion of RESET_n SHALL take effect at the next rising CLK edge; no fetch SHALL start until render_en=1.

Verification
REQ-029 Reset: assert RESET_n=0 mid-fetch (phase 5) -> the next sampled outputs are mem_addr=0x2000, mem_rd=0, pix_valid=0, and phase=0 after release.
REQ-030 Address sequence: line_start with nt=1, cx=3, cy=5, fine_y=2, pattern_base=1, memory NT byte=0x24 -> mem_addr is 0x24A3 x2, 0x27C8 x2, 0x1242 x2, 0x124A x2.
REQ-031 Pixel pipeline: two tiles, PT_LO=0xF0, PT_HI=0x0F, attr field=2, fine_x=0 -> pix_valid rises 16 cycles after line_start, and pix_out is 0x9 x4 then 0xA x4.
REQ-032 Wrap: cx_in=31, nt=0 -> the second NT fetch address is 0x2400 | cy<<5.
REQ-033 Freeze and abort: render_en=0 for 5 cycles at phase 3 -> mem_addr, shifters and pix_out are unchanged. Then line_start at phase 6 -> phase=0, pix_valid=0, and the new coordinates are used.
REQ-034 fine_x sweep: with fixed shifters, fine_x=0..7 selects shifter bits 15..8 on pix_out.
